// File: rtl/sdm_fcw_ramp.sv
// Frequency-control-word ramp sequencer for a sigma-delta fractional-N loop.
// Walks the word {n_o, frac_o} from its present value to a captured target
// in steps of at most S frac LSBs, one step every R+1 reference cycles, so
// that the synthesizer never sees a frequency jump large enough to unlock.
module sdm_fcw_ramp #(
  parameter int RST_N    = 31,
  parameter int RST_FRAC = 416,
  parameter int N_MIN    = 16,
  parameter int N_MAX    = 60
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [5:0] tgt_n,
  input  logic [9:0] tgt_frac,
  input  logic [9:0] step,
  input  logic [7:0] rate,
  output logic [5:0] n_o,
  output logic [9:0] frac_o,
  output logic       upd_o,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0]  N_MIN_W = 6'(N_MIN);
  localparam logic [5:0]  N_MAX_W = 6'(N_MAX);
  localparam logic [15:0] RST_W   = {6'(RST_N), 10'(RST_FRAC)};

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t      state_reg;
  logic [15:0] w_reg;      // current word, N*1024 + frac
  logic [15:0] t_reg;      // captured (clamped) target
  logic [9:0]  s_reg;      // captured step, never zero
  logic [7:0]  r_reg;      // captured update period minus one
  logic [7:0]  cnt_reg;    // cycles left before the next update
  logic        upd_reg;
  logic        done_reg;
  logic        busy_reg;

  logic [15:0] clamp_t_next;
  logic [9:0]  s_eff_next;
  logic [16:0] diff_next;
  logic [16:0] mag_next;
  logic        near_next;
  logic [15:0] w_step_next;
  logic        hit_next;

  // Target clamp, step sanitising and distance-to-target arithmetic.
  always_comb begin
    clamp_t_next = {tgt_n, tgt_frac};
    if (tgt_n < N_MIN_W) begin
      clamp_t_next = {N_MIN_W, 10'd0};
    end else if (tgt_n > N_MAX_W) begin
      clamp_t_next = {N_MAX_W, 10'h3FF};
    end

    s_eff_next = (step == 10'd0) ? 10'd1 : step;

    // 17-bit difference: the word is 16-bit unsigned, so this never wraps.
    diff_next   = {1'b0, t_reg} - {1'b0, w_reg};
    mag_next    = diff_next[16] ? (~diff_next + 17'd1) : diff_next;
    near_next   = (mag_next <= {7'd0, s_reg});
    w_step_next = diff_next[16] ? (w_reg - {6'd0, s_reg})
                                : (w_reg + {6'd0, s_reg});

    hit_next = (clamp_t_next == w_reg);
  end

  // Ramp state machine; every output is a register so the loop sees clean edges.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      w_reg     <= RST_W;
      t_reg     <= RST_W;
      s_reg     <= 10'd1;
      r_reg     <= 8'd0;
      cnt_reg   <= 8'd0;
      upd_reg   <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      upd_reg  <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            t_reg <= clamp_t_next;
            s_reg <= s_eff_next;
            r_reg <= rate;
            if (hit_next) begin
              // Already there: acknowledge without touching the word.
              done_reg <= 1'b1;
            end else begin
              state_reg <= RAMP;
              busy_reg  <= 1'b1;
              cnt_reg   <= rate;
            end
          end
        end

        RAMP: begin
          if (load) begin
            // Retarget: restart the period from here, never step on this edge.
            t_reg   <= clamp_t_next;
            s_reg   <= s_eff_next;
            r_reg   <= rate;
            cnt_reg <= rate;
            if (hit_next) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else if (cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
          end else if (near_next) begin
            // Last step lands exactly on the target.
            w_reg     <= t_reg;
            upd_reg   <= 1'b1;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            w_reg   <= w_step_next;
            upd_reg <= 1'b1;
            cnt_reg <= r_reg;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign n_o    = w_reg[15:10];
  assign frac_o = w_reg[9:0];
  assign upd_o  = upd_reg;
  assign done   = done_reg;
  assign busy   = busy_reg;

endmodule

// File: doc/sdm_fcw_ramp.md
# sdm_fcw_ramp

Frequency-control-word sequencer that sits directly upstream of the sigma-delta fractional-N divider loop. It drives that loop's integer modulus `N` and fractional word `frac`. On a load request it walks the programmed word from its current value to a new target in bounded steps at a programmable rate. This avoids frequency jumps large enough to unlock the synthesizer. Both the divider loop and this block run on the same reference clock.

## Interface
Parameters:
- `RST_N`, 31: `n_o` value at reset.
- `RST_FRAC`, 416: `frac_o` value at reset.
- `N_MIN`, 16: lowest legal integer modulus.
- `N_MAX`, 60: highest legal integer modulus.

Ports:
- `clk`  in  1  reference clock; all logic on its rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `load`  in  1  one-cycle request; samples `tgt_n`, `tgt_frac`, `step`, `rate`.
- `tgt_n`  in  6  target integer modulus.
- `tgt_frac`  in  10  target fractional word (units of 1/1024).
- `step`  in  10  maximum change per update, in frac LSBs; 0 is treated as 1.
- `rate`  in  8  update period minus 1, in `clk` cycles.
- `n_o`  out  6  integer modulus to the divider loop (`N`).
- `frac_o`  out  10  fractional word to the divider loop (`frac`).
- `upd_o`  out  1  one-cycle pulse in the cycle a new word first appears.
- `busy`  out  1  high while a ramp is in progress.
- `done`  out  1  one-cycle pulse when the target is reached.

## Operation
- Internal word W = {n_o, frac_o}: 16-bit unsigned, value N*1024+frac.
- Arithmetic: the signed difference uses 17 bits; no wrap-around is possible.
- Target clamp on capture, applied before the difference is computed:
  - tgt_n < N_MIN gives T = {N_MIN, 0}.
  - tgt_n > N_MAX gives T = {N_MAX, 1023}.
- Registered snapshots at load: T, S = max(step, 1), R = rate.
- States: IDLE, RAMP.
- IDLE + load:
  - T == W: stay in IDLE; `done` pulses the next cycle; no `upd_o`.
  - Otherwise: go to RAMP and set the counter to R.
- RAMP, each edge:
  - Counter != 0: decrement.
  - Counter == 0 and |T−W| > S: W moves toward T by S, `upd_o` pulses, counter reloads R.
  - Counter == 0 and |T−W| ≤ S: W = T, `upd_o` and `done` pulse, `busy` drops, state returns to IDLE.
- `load` during RAMP (retarget):
  - New T/S/R are captured and the counter reloads R.
  - The ramp continues from the current W; no update occurs at that edge even if the counter was 0.
  - If the new T == W: go to IDLE and pulse `done` the next cycle.
- Outputs are glitch-free: W changes only on update edges, and `n_o`/`frac_o` change on the same edge.
- Reset (asserted at any time, including mid-ramp):
  - Immediately: W = {RST_N, RST_FRAC}, state IDLE, counter 0.
  - `busy`, `upd_o`, `done` = 0.

## Timing
- All outputs are registered.
- Load at edge k: `busy` is high after edge k.
- First update at edge k+R+1; subsequent updates every R+1 cycles.
- Number of updates = ceil(|T−W| / S).
- The final update edge raises `done` and `upd_o` for one cycle and lowers `busy` on that same edge.
- Reset release: the first `load` is accepted on the first rising edge with `rstn` high.

## Test plan
- Reset values: hold `rstn` low 10 cycles, then release.
  - -> n_o=31, frac_o=416, busy=0, upd_o=0, done=0, before and after release.
- Ramp up: load tgt 32/0, step 100, rate 3.
  - -> 7 updates, 4 cycles apart: 31/516, 616, 716, 816, 916, 1016, then 32/0.
  - -> done pulses with the 7th update, 28 cycles after the load edge; busy high in between.
- Ramp down with step=0: from 32/0, load tgt 31/1020, rate 0.
  - -> 4 consecutive updates: 31/1023, 1022, 1021, 1020; done on the last.
- Retarget mid-ramp: during the up-ramp, after update 31/716, load tgt 31/600, step 100, rate 1.
  - -> updates to 31/616, then 31/600, each 2 cycles apart; a single done.
- Same target and clamp:
  - Load tgt == current W -> done one cycle later, no upd_o.
  - Load tgt_n=5 -> ramp ends at n_o=16, frac_o=0.
- Reset mid-ramp: assert `rstn` between updates.
  - -> outputs return asynchronously to 31/416 with busy=0.
  - -> no further updates after release until a new load.
